// File: rtl/lab3_mem_line_mem_responder.sv
// Purpose : test-harness main memory; serves one line (16 B) or word (4 B) read/write at a time.
// Latency : response valid p_latency+1 cycles after the accept cycle.
// Backpres: memreq_rdy is low while a request is in flight; the response is held until memresp_rdy.
// Ports   : clk/reset (sync, active-high); memreq_* request stream (val/rdy, type, opaque,
//           addr, len, data); memresp_* response stream (val/rdy, type, opaque, test, len, data).
module lab3_mem_line_mem_responder #(
   parameter int p_num_lines = 256,
   parameter int p_latency   = 0
) (
   input  logic         clk,
   input  logic         reset,

   input  logic         memreq_val,
   output logic         memreq_rdy,
   input  logic [3:0]   memreq_type,
   input  logic [7:0]   memreq_opaque,
   input  logic [31:0]  memreq_addr,
   input  logic [3:0]   memreq_len,
   input  logic [127:0] memreq_data,

   output logic         memresp_val,
   input  logic         memresp_rdy,
   output logic [3:0]   memresp_type,
   output logic [7:0]   memresp_opaque,
   output logic [1:0]   memresp_test,
   output logic [3:0]   memresp_len,
   output logic [127:0] memresp_data
);

   localparam int IW = $clog2(p_num_lines);

   localparam logic [3:0] TYPE_READ       = 4'd0;
   localparam logic [3:0] TYPE_WRITE      = 4'd1;
   localparam logic [3:0] TYPE_WRITE_INIT = 4'd2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t         state_q, state_d;
   logic [7:0]     cnt_q, cnt_d;
   logic [3:0]     type_q, type_d;
   logic [7:0]     opaque_q, opaque_d;
   logic [3:0]     len_q, len_d;
   logic [127:0]   data_q, data_d;

   logic [127:0]   mem_q [p_num_lines];

   logic           accept;
   logic [IW-1:0]  idx;
   logic [6:0]     wbit;
   logic [127:0]   cur_line;
   logic [31:0]    cur_word;
   logic [127:0]   wr_line;
   logic           wr_en;

   // Address bits outside the line index and word select are intentionally ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{memreq_addr[31:IW+4], memreq_addr[1:0]};

   always_comb begin
      accept   = (state_q == S_IDLE) && memreq_val;
      idx      = memreq_addr[IW+3:4];
      wbit     = {memreq_addr[3:2], 5'b0};
      // Read data comes from storage as it stands before this edge's write.
      cur_line = mem_q[idx];
      cur_word = cur_line[wbit +: 32];

      wr_line  = cur_line;
      if (memreq_len == 4'd0) begin
         wr_line = memreq_data;
      end else begin
         wr_line[wbit +: 32] = memreq_data[31:0];
      end
      wr_en = accept && ((memreq_type == TYPE_WRITE) || (memreq_type == TYPE_WRITE_INIT));

      state_d  = state_q;
      cnt_d    = cnt_q;
      type_d   = type_q;
      opaque_d = opaque_q;
      len_d    = len_q;
      data_d   = data_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               type_d   = memreq_type;
               opaque_d = memreq_opaque;
               len_d    = memreq_len;
               if (memreq_type == TYPE_READ) begin
                  data_d = (memreq_len == 4'd0) ? cur_line : {96'b0, cur_word};
               end else begin
                  data_d = '0;
               end
               if (p_latency == 0) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = 8'(p_latency - 1);
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 8'd0) begin
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_RESP: begin
            if (memresp_rdy) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         type_q   <= '0;
         opaque_q <= '0;
         len_q    <= '0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         type_q   <= type_d;
         opaque_q <= opaque_d;
         len_q    <= len_d;
         data_q   <= data_d;
      end
   end

   // Reset wipes storage, including a write committed by an aborted request.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < p_num_lines; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en) begin
         mem_q[idx] <= wr_line;
      end
   end

   assign memreq_rdy     = (state_q == S_IDLE) && !reset;
   assign memresp_val    = (state_q == S_RESP);
   assign memresp_type   = type_q;
   assign memresp_opaque = opaque_q;
   assign memresp_test   = 2'b00;
   assign memresp_len    = len_q;
   assign memresp_data   = data_q;

endmodule

// File: tb/tb_lab3_mem_line_mem_responder.sv
// Purpose : directed bench for the memory responder; two instances (256 lines/latency 0,
//           4 lines/latency 3) share stimulus, a select steers requests and outputs.
module tb_lab3_mem_line_mem_responder;

   logic         clk = 1'b0;
   logic         reset;
   logic         sel;
   logic         req_val;
   logic [3:0]   req_type;
   logic [7:0]   req_opaque;
   logic [31:0]  req_addr;
   logic [3:0]   req_len;
   logic [127:0] req_data;
   logic         resp_rdy;

   logic         rdy0, val0, rdy1, val1;
   logic [3:0]   type0, type1, len0, len1;
   logic [7:0]   op0, op1;
   logic [1:0]   test0, test1;
   logic [127:0] data0, data1;

   logic         rdy, val;
   logic [3:0]   rtype, rlen;
   logic [7:0]   rop;
   logic [1:0]   rtest;
   logic [127:0] rdat;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   lab3_mem_line_mem_responder #(.p_num_lines(256), .p_latency(0)) dut0 (
      .clk(clk), .reset(reset),
      .memreq_val(req_val & ~sel), .memreq_rdy(rdy0), .memreq_type(req_type),
      .memreq_opaque(req_opaque), .memreq_addr(req_addr), .memreq_len(req_len),
      .memreq_data(req_data),
      .memresp_val(val0), .memresp_rdy(resp_rdy & ~sel), .memresp_type(type0),
      .memresp_opaque(op0), .memresp_test(test0), .memresp_len(len0), .memresp_data(data0)
   );

   lab3_mem_line_mem_responder #(.p_num_lines(4), .p_latency(3)) dut1 (
      .clk(clk), .reset(reset),
      .memreq_val(req_val & sel), .memreq_rdy(rdy1), .memreq_type(req_type),
      .memreq_opaque(req_opaque), .memreq_addr(req_addr), .memreq_len(req_len),
      .memreq_data(req_data),
      .memresp_val(val1), .memresp_rdy(resp_rdy & sel), .memresp_type(type1),
      .memresp_opaque(op1), .memresp_test(test1), .memresp_len(len1), .memresp_data(data1)
   );

   assign rdy   = sel ? rdy1  : rdy0;
   assign val   = sel ? val1  : val0;
   assign rtype = sel ? type1 : type0;
   assign rlen  = sel ? len1  : len0;
   assign rop   = sel ? op1   : op0;
   assign rtest = sel ? test1 : test0;
   assign rdat  = sel ? data1 : data0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // One request/response transaction. Starts and ends on a falling edge.
   task automatic do_req(input logic s, input logic [3:0] t, input logic [7:0] op,
                         input logic [31:0] a, input logic [3:0] l, input logic [127:0] d,
                         input int exp_lat, input int hold, input logic rst_in_resp,
                         output logic [127:0] rd);
      int k;
      sel = s; req_type = t; req_opaque = op; req_addr = a; req_len = l; req_data = d;
      req_val = 1'b1;
      k = 0;
      while (!rdy && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("req_rdy", {127'b0, rdy}, 128'd1);
      @(posedge clk);
      #1 req_val = 1'b0;
      k = 1;
      @(negedge clk);
      while (!val && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("latency", 128'(k), 128'(exp_lat + 1));
      chk("resp_type", {124'b0, rtype}, {124'b0, t});
      chk("resp_opaque", {120'b0, rop}, {120'b0, op});
      chk("resp_len", {124'b0, rlen}, {124'b0, l});
      chk("resp_test", {126'b0, rtest}, 128'd0);
      rd = rdat;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("stall_val", {127'b0, val}, 128'd1);
         chk("stall_req_rdy", {127'b0, rdy}, 128'd0);
         chk("stall_data", rdat, rd);
      end
      if (rst_in_resp) begin
         reset = 1'b1;
         @(negedge clk);
         chk("rst_val", {127'b0, val}, 128'd0);
         reset = 1'b0;
         @(negedge clk);
         chk("rst_req_rdy", {127'b0, rdy}, 128'd1);
      end else begin
         resp_rdy = 1'b1;
         @(posedge clk);
         #1 resp_rdy = 1'b0;
         @(negedge clk);
         chk("post_req_rdy", {127'b0, rdy}, 128'd1);
         chk("post_val", {127'b0, val}, 128'd0);
      end
   endtask

   localparam logic [127:0] LINE_A  = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [127:0] LINE_AA = 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA;
   localparam logic [127:0] LINE_C  = 128'hCAFEF00D_11223344_55667788_99AABBCC;

   initial begin
      logic [127:0] r;
      reset = 1'b1; sel = 1'b0; req_val = 1'b0; req_type = '0; req_opaque = '0;
      req_addr = '0; req_len = '0; req_data = '0; resp_rdy = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req_rdy0", {127'b0, rdy0}, 128'd0);
      chk("rst_val0", {127'b0, val0}, 128'd0);
      chk("rst_data0", data0, 128'd0);
      chk("rst_fields0", {112'b0, type0, op0, len0}, 128'd0);
      chk("rst_req_rdy1", {127'b0, rdy1}, 128'd0);
      chk("rst_val1", {127'b0, val1}, 128'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_req_rdy0", {127'b0, rdy0}, 128'd1);
      chk("idle_val0", {127'b0, val0}, 128'd0);

      // latency 0 instance
      do_req(1'b0, 4'd0, 8'h11, 32'h40, 4'd0, '0, 0, 0, 1'b0, r);
      chk("read_zero", r, 128'd0);
      do_req(1'b0, 4'd1, 8'h5A, 32'h100, 4'd0, LINE_A, 0, 0, 1'b0, r);
      chk("write_data0", r, 128'd0);
      do_req(1'b0, 4'd0, 8'h22, 32'h100, 4'd0, '0, 0, 0, 1'b0, r);
      chk("read_back", r, LINE_A);
      do_req(1'b0, 4'd2, 8'h33, 32'h200, 4'd0, LINE_AA, 0, 0, 1'b0, r);
      chk("winit_data0", r, 128'd0);
      do_req(1'b0, 4'd1, 8'h34, 32'h208, 4'd1, 128'hFFFF0000_DEADBEEF, 0, 0, 1'b0, r);
      chk("wword_data0", r, 128'd0);
      do_req(1'b0, 4'd0, 8'h35, 32'h200, 4'd0, '0, 0, 0, 1'b0, r);
      chk("merged_line", r, 128'hAAAAAAAA_DEADBEEF_AAAAAAAA_AAAAAAAA);
      do_req(1'b0, 4'd0, 8'h36, 32'h20B, 4'd3, '0, 0, 0, 1'b0, r);
      chk("word_read", r, {96'b0, 32'hDEADBEEF});
      do_req(1'b0, 4'd5, 8'h37, 32'h100, 4'd0, {128{1'b1}}, 0, 0, 1'b0, r);
      chk("unsup_data0", r, 128'd0);
      do_req(1'b0, 4'd0, 8'h38, 32'h100, 4'd0, '0, 0, 0, 1'b0, r);
      chk("unsup_nochange", r, LINE_A);

      // latency 3, 4-line instance
      do_req(1'b1, 4'd1, 8'h41, 32'h40, 4'd0, LINE_C, 3, 5, 1'b0, r);
      chk("lat3_write_data0", r, 128'd0);
      do_req(1'b1, 4'd0, 8'h42, 32'h00, 4'd0, '0, 3, 0, 1'b0, r);
      chk("alias_read", r, LINE_C);
      do_req(1'b1, 4'd0, 8'h43, 32'h00, 4'd0, '0, 3, 0, 1'b1, r);
      chk("pre_reset_read", r, LINE_C);
      do_req(1'b1, 4'd0, 8'h44, 32'h00, 4'd0, '0, 3, 0, 1'b0, r);
      chk("post_reset_zero", r, 128'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/lab3_mem_line_mem_responder.md
# lab3_mem_line_mem_responder

Memory-side responder for the cache refill/evict interface: accepts one request at a time from a blocking cache on the cache-to-memory request stream, performs a line (16 B) or word (4 B) read/write against an internal array, and returns a response after a programmable fixed latency. It sits below the base/alternative caches in lab3 test harnesses and composed cache-memory systems, standing in for main memory with deterministic, cycle-exact timing.

## Interface

- p_num_lines, 256: lines of storage; power of two, at least 2; index width IW = log2(p_num_lines).
- p_latency, 0: extra cycles between request acceptance and response valid; 0–255.

Ports:

- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- memreq_val  in  1  request valid.
- memreq_rdy  out  1  request ready.
- memreq_type  in  4  0 = READ, 1 = WRITE, 2 = WRITE_INIT; others unsupported.
- memreq_opaque  in  8  tag echoed in response.
- memreq_addr  in  32  byte address.
- memreq_len  in  4  0 = line (16 B); any nonzero value = word (4 B).
- memreq_data  in  128  write data; word accesses use [31:0].
- memresp_val  out  1  response valid.
- memresp_rdy  in  1  response ready.
- memresp_type  out  4  echo of request type.
- memresp_opaque  out  8  echo of request opaque.
- memresp_test  out  2  always 2'b00.
- memresp_len  out  4  echo of request len.
- memresp_data  out  128  read data, or zero.

## Operation

- Storage: p_num_lines × 128-bit entries.
  - Line index = addr[IW+3:4]. Higher address bits are ignored, so addresses alias modulo 16·p_num_lines bytes.
  - Word select = addr[3:2]. addr[1:0] is ignored.
- All storage entries are cleared to zero while reset is high.
- FSM states: IDLE, WAIT, RESP. State resets to IDLE.
- IDLE:
  - memreq_rdy = 1.
  - On memreq_val, the request is accepted.
  - Next state is RESP if p_latency = 0, else WAIT with the counter loaded to p_latency−1.
- WAIT:
  - memreq_rdy = 0.
  - Counter decrements each cycle.
  - Moves to RESP in the cycle the counter is 0.
- RESP:
  - memresp_val = 1, memreq_rdy = 0.
  - On memresp_rdy, moves to IDLE; otherwise holds.
- Acceptance edge (the clock edge ending the accept cycle) does all of the following together:
  - Latches type, opaque and len into response registers.
  - Computes read data from the storage contents before any write at that edge.
  - Commits any write at that same edge.
- READ, len 0: memresp_data = the entire line.
- READ, word: memresp_data[31:0] = the selected word; [127:32] = 0.
- WRITE / WRITE_INIT, len 0:
  - The line is replaced with memreq_data.
  - memresp_data = 0.
- WRITE / WRITE_INIT, word:
  - Only the selected word is replaced, with memreq_data[31:0]; the other three words are unchanged.
  - memresp_data = 0.
- Unsupported type:
  - No storage change.
  - A response is still returned: type echoed, memresp_data = 0.
- Response fields are stable from memresp_val rising until the handshake.
- No pipelining: only one request is outstanding at a time.

## Timing

- Reset values (while reset is high and in the cycle after): memreq_rdy = 0 during reset, then 1 in IDLE. memresp_val = 0. All response registers = 0. Counter = 0.
- If the request is accepted in cycle T, memresp_val first rises in cycle T+1+p_latency.
- Response handshake in cycle R → IDLE in R+1, where memreq_rdy = 1 again.
- Minimum request spacing = p_latency+2 cycles (p_latency = 0: accept every 2 cycles with memresp_rdy tied high).
- memresp_rdy asserted early (during IDLE/WAIT) has no effect.
- memreq_val with memreq_rdy = 0 is ignored. The requester must hold its request stable until it is accepted.
- Reset mid-operation (WAIT or RESP):
  - The in-flight response is dropped; memresp_val = 0 from the cycle after reset is sampled.
  - Storage is zeroed, including any write committed at acceptance.
- Write-then-read to the same address on consecutive requests: the read returns the new data.

## Test plan

- After reset, line READ from addr 0x00000040 → memresp_val in cycle T+1, data 128'h0, type 0, opaque echoed, test 2'b00.
- Line WRITE of 128'h0123…CDEF (opaque 0x5A) to 0x00000100, then line READ of the same address:
  - WRITE response: data 0, opaque 0x5A.
  - READ response: data = the written line.
- WRITE_INIT line 0xAAAA…AAAA to 0x200, then word WRITE 0xDEADBEEF to 0x208, then line READ of 0x200 → line = 0xAAAAAAAA_DEADBEEF_AAAAAAAA_AAAAAAAA (word 2 = 0xDEADBEEF, words 3/1/0 = 0xAAAAAAAA).
- Word READ of 0x20B returns memresp_data = {96'b0, 32'hDEADBEEF}.
- p_latency = 3:
  - Accept at T → memresp_val at T+4.
  - memresp_rdy held low for 5 cycles: val and data stay stable, memreq_rdy stays 0.
  - Handshake at R → memreq_rdy = 1 at R+1.
- Aliasing and reset:
  - p_num_lines = 4: a line write to 0x40 is read back from 0x00.
  - Reset asserted in RESP: memresp_val drops and the previously written line reads 0.
